// File: rtl/sequential_access_bench_pkg.sv
// rtl/sequential_access_bench_pkg.sv - shared constants for the sequential access engine
package sequential_access_bench_pkg;

    localparam logic [1:0] MODE_WRITE  = 2'd0;
    localparam logic [1:0] MODE_READ   = 2'd1;
    localparam logic [1:0] MODE_VERIFY = 2'd2;
    localparam logic [1:0] MODE_IDLE   = 2'd3;

    localparam logic [3:0] ST_FETCH0 = 4'd0;
    localparam logic [3:0] ST_LATCH0 = 4'd1;
    localparam logic [3:0] ST_FETCH1 = 4'd2;
    localparam logic [3:0] ST_LATCH1 = 4'd3;
    localparam logic [3:0] ST_FETCH2 = 4'd4;
    localparam logic [3:0] ST_LATCH2 = 4'd5;
    localparam logic [3:0] ST_RUN    = 4'd6;
    localparam logic [3:0] ST_DRAIN  = 4'd7;
    localparam logic [3:0] ST_REP0   = 4'd8;
    localparam logic [3:0] ST_REP1   = 4'd9;
    localparam logic [3:0] ST_IDLE   = ST_FETCH0;

    localparam int MODE_LSB   = 0;
    localparam int STRIDE_LSB = 4;
    localparam int START_LSB  = 16;

    function automatic logic mode_reads(input logic [1:0] mode);
        return (mode == MODE_READ) || (mode == MODE_VERIFY);
    endfunction

endpackage

// File: rtl/seq_access_pattern.sv
// rtl/seq_access_pattern.sv - address/stride accumulator and SIMD lane pattern generator
module seq_access_pattern
    import sequential_access_bench_pkg::*;
#(
    parameter int SIMD_WIDTH = 4,
    parameter int W_D        = 32,
    parameter int W_A        = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      step,
    input  logic [W_A-1:0]            start,
    input  logic [W_A-1:0]            stride,
    input  logic [W_D-1:0]            seed,
    output logic [W_A-1:0]            addr,
    output logic [W_D*SIMD_WIDTH-1:0] pattern,
    output logic [W_D*SIMD_WIDTH-1:0] pattern_d
);

    logic [W_D-1:0] base;

    // step is withheld on the last access so the address holds after the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            base      <= '0;
            pattern_d <= '0;
        end else begin
            if (load) begin
                addr <= start;
                base <= seed;
            end else if (step) begin
                addr <= addr + stride;
                base <= base + W_D'(SIMD_WIDTH);
            end
            pattern_d <= pattern;
        end
    end

    for (genvar l = 0; l < SIMD_WIDTH; l++) begin : g_lane
        assign pattern[l*W_D +: W_D] = base + W_D'(l);
    end

endmodule

// File: rtl/sequential_access_bench.sv
// rtl/sequential_access_bench.sv - programmable write/read/verify/idle sweep engine over a SIMD memory
module sequential_access_bench
    import sequential_access_bench_pkg::*;
#(
    parameter int SIMD_WIDTH = 4,
    parameter int W_D        = 32,
    parameter int W_A        = 12,
    parameter int W_COMM_D   = 32
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    output logic [W_A-1:0]            mem_addr,
    output logic [W_D*SIMD_WIDTH-1:0] mem_d,
    output logic                      mem_we,
    input  logic [W_D*SIMD_WIDTH-1:0] mem_q,
    input  logic [W_COMM_D-1:0]       comm_q,
    input  logic                      comm_empty,
    output logic                      comm_deq,
    output logic [W_COMM_D-1:0]       comm_d,
    output logic                      comm_enq,
    input  logic                      comm_full
);

    localparam int W_P = W_D * SIMD_WIDTH;

    logic [3:0]     state;
    logic [3:0]     state_nx;
    logic [W_A:0]   len_r;
    logic [W_A:0]   idx;
    logic [1:0]     mode_r;
    logic [W_A-1:0] start_r;
    logic [W_A-1:0] stride_r;
    logic [31:0]    cycles;
    logic [31:0]    result;
    logic           rd_pending;
    logic [W_P-1:0] pattern;
    logic [W_P-1:0] pattern_d;
    logic [31:0]    wr_sum;
    logic [31:0]    rd_sum;
    logic [W_D-1:0] seed_w;
    logic           in_fetch;
    logic           in_rep;
    logic           in_run;
    logic           last_access;
    logic           load;
    logic           step;

    assign in_fetch    = (state == ST_FETCH0) || (state == ST_FETCH1) || (state == ST_FETCH2);
    assign in_rep      = (state == ST_REP0) || (state == ST_REP1);
    assign in_run      = (state == ST_RUN);
    assign last_access = (idx == len_r - 1'b1);
    assign load        = (state == ST_LATCH2) && (len_r != '0);
    assign step        = in_run && !last_access;
    assign seed_w      = W_D'(comm_q);

    seq_access_pattern #(
        .SIMD_WIDTH (SIMD_WIDTH),
        .W_D        (W_D),
        .W_A        (W_A)
    ) u_pattern (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (load),
        .step       (step),
        .start      (start_r),
        .stride     (stride_r),
        .seed       (seed_w),
        .addr       (mem_addr),
        .pattern    (pattern),
        .pattern_d  (pattern_d)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH0: if (!comm_empty) state_nx = ST_LATCH0;
            ST_LATCH0: state_nx = ST_FETCH1;
            ST_FETCH1: if (!comm_empty) state_nx = ST_LATCH1;
            ST_LATCH1: state_nx = ST_FETCH2;
            ST_FETCH2: if (!comm_empty) state_nx = ST_LATCH2;
            ST_LATCH2: state_nx = (len_r == '0) ? ST_REP0 : ST_RUN;
            ST_RUN:    if (last_access) state_nx = ST_DRAIN;
            ST_DRAIN:  state_nx = ST_REP0;
            ST_REP0:   if (!comm_full) state_nx = ST_REP1;
            ST_REP1:   if (!comm_full) state_nx = ST_FETCH0;
            default:   state_nx = ST_FETCH0;
        endcase
    end

    always_comb begin
        wr_sum = '0;
        rd_sum = '0;
        for (int l = 0; l < SIMD_WIDTH; l++) begin
            wr_sum = wr_sum + 32'(pattern[l*W_D +: W_D]);
            rd_sum = rd_sum + 32'(mem_q[l*W_D +: W_D]);
        end
    end

    // FETCH0 is the reset state, so the dequeue strobe must be gated by reset itself
    assign comm_deq = RST_N && in_fetch && !comm_empty;
    assign comm_enq = in_rep && !comm_full;
    assign comm_d   = !comm_enq ? '0 : (state == ST_REP0) ? W_COMM_D'(cycles) : W_COMM_D'(result);
    assign mem_we   = in_run && (mode_r == MODE_WRITE);
    assign mem_d    = mem_we ? pattern : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            len_r      <= '0;
            mode_r     <= MODE_WRITE;
            start_r    <= '0;
            stride_r   <= '0;
            idx        <= '0;
            cycles     <= '0;
            result     <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_pending <= in_run && mode_reads(mode_r);
            case (state)
                ST_LATCH0: len_r <= comm_q[W_A:0];
                ST_LATCH1: begin
                    mode_r   <= comm_q[MODE_LSB +: 2];
                    stride_r <= comm_q[STRIDE_LSB +: W_A];
                    start_r  <= comm_q[START_LSB +: W_A];
                end
                ST_LATCH2: begin
                    idx    <= '0;
                    cycles <= '0;
                    result <= '0;
                end
                ST_RUN: begin
                    idx    <= idx + 1'b1;
                    cycles <= cycles + 32'd1;
                    if (mode_r == MODE_WRITE) result <= result + wr_sum;
                end
                ST_DRAIN: cycles <= cycles + 32'd1;
                default: ;
            endcase
            // read data lags its address by one cycle; DRAIN catches the final word
            if (rd_pending) begin
                if (mode_r == MODE_READ) begin
                    result <= result + rd_sum;
                end else if ((mem_q != pattern_d) && (result != '1)) begin
                    result <= result + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequential_access_bench.sv
// tb/tb_sequential_access_bench.sv - directed bench for sequential_access_bench at SIMD 1 and 4
module tb_sequential_access_bench;
    import sequential_access_bench_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0]  a_addr;
    logic [31:0]  a_d, a_q, a_cq, a_cd;
    logic         a_we, a_empty, a_deq, a_enq;
    logic         a_full = 1'b0;
    logic [31:0]  mem_a [0:4095];
    logic [31:0]  cmd_a [0:63];
    int           na = 0, rda = 0, ra = 0;
    logic [31:0]  rep_a[$];
    logic [11:0]  wlog_a[$];
    logic         both_a = 1'b0;
    logic         poke_en = 1'b0;
    logic [11:0]  poke_addr = '0;
    logic [31:0]  poke_data = '0;

    logic [11:0]  b_addr;
    logic [127:0] b_d, b_q;
    logic [31:0]  b_cq, b_cd;
    logic         b_we, b_empty, b_deq, b_enq;
    logic         b_full = 1'b0;
    logic [127:0] mem_b [0:4095];
    logic [31:0]  cmd_b [0:63];
    int           nb = 0, rdb = 0, rb = 0;
    logic [31:0]  rep_b[$];

    assign a_empty = (rda == na);
    assign b_empty = (rdb == nb);

    sequential_access_bench #(.SIMD_WIDTH(1), .W_D(32), .W_A(12), .W_COMM_D(32)) dut_a (
        .CLK(clk), .RST_N(rst_n), .mem_addr(a_addr), .mem_d(a_d), .mem_we(a_we), .mem_q(a_q),
        .comm_q(a_cq), .comm_empty(a_empty), .comm_deq(a_deq), .comm_d(a_cd), .comm_enq(a_enq),
        .comm_full(a_full)
    );

    sequential_access_bench #(.SIMD_WIDTH(4), .W_D(32), .W_A(12), .W_COMM_D(32)) dut_b (
        .CLK(clk), .RST_N(rst_n), .mem_addr(b_addr), .mem_d(b_d), .mem_we(b_we), .mem_q(b_q),
        .comm_q(b_cq), .comm_empty(b_empty), .comm_deq(b_deq), .comm_d(b_cd), .comm_enq(b_enq),
        .comm_full(b_full)
    );

    always @(posedge clk) begin
        if (a_we) begin
            mem_a[a_addr] <= a_d;
            wlog_a.push_back(a_addr);
        end
        if (poke_en) mem_a[poke_addr] <= poke_data;
        a_q <= mem_a[a_addr];
        if (a_deq) begin
            a_cq <= cmd_a[rda[5:0]];
            rda  <= rda + 1;
        end
        if (a_enq) rep_a.push_back(a_cd);
        if (a_deq && a_enq) both_a <= 1'b1;

        if (b_we) mem_b[b_addr] <= b_d;
        b_q <= mem_b[b_addr];
        if (b_deq) begin
            b_cq <= cmd_b[rdb[5:0]];
            rdb  <= rdb + 1;
        end
        if (b_enq) rep_b.push_back(b_cd);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w1(input logic [11:0] start, input logic [11:0] stride,
                                       input logic [1:0] mode);
        return {4'b0, start, stride, 2'b0, mode};
    endfunction

    task automatic push_word(input int sel, input logic [31:0] w);
        if (sel == 0) begin
            cmd_a[na] = w;
            na++;
        end else begin
            cmd_b[nb] = w;
            nb++;
        end
    endtask

    task automatic send_cmd(input int sel, input logic [31:0] len, input logic [11:0] start,
                            input logic [11:0] stride, input logic [1:0] mode, input logic [31:0] seed);
        push_word(sel, len);
        push_word(sel, w1(start, stride, mode));
        push_word(sel, seed);
    endtask

    task automatic expect_report(input int sel, input logic [31:0] exp_c, input logic [31:0] exp_r,
                                 input string tag);
        int k;
        int base;
        k    = 0;
        base = (sel == 0) ? ra : rb;
        while ((((sel == 0) ? rep_a.size() : rep_b.size()) < base + 2) && k < 400) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        assert (k < 400) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed %0d cycles expected report within 400", tag, k);
        end
        if (k < 400) begin
            check({tag, "_cycles"}, (sel == 0) ? rep_a[base] : rep_b[base], exp_c);
            check({tag, "_result"}, (sel == 0) ? rep_a[base+1] : rep_b[base+1], exp_r);
        end
        if (sel == 0) ra = base + 2;
        else          rb = base + 2;
    endtask

    initial begin
        int k;
        int enq_seen;

        // command already queued while in reset: no dequeue may happen yet
        send_cmd(0, 4, 12'h010, 12'd1, MODE_WRITE, 32'h100);
        repeat (3) @(negedge clk);
        check("rst_mem_addr", a_addr, 0);
        check("rst_mem_we", a_we, 0);
        check("rst_mem_d", a_d, 0);
        check("rst_comm_deq", a_deq, 0);
        check("rst_comm_enq", a_enq, 0);
        check("rst_comm_d", a_cd, 0);
        check("rst_state", dut_a.state, ST_IDLE);
        rst_n = 1'b1;

        expect_report(0, 5, 32'h406, "write");
        check("write_count", wlog_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("write_addr", wlog_a[i], 12'h010 + i);
            check("write_data", mem_a[12'h010 + i], 32'h100 + i);
        end

        send_cmd(0, 4, 12'h010, 12'd1, MODE_READ, 32'h0);
        expect_report(0, 5, 32'h406, "read");
        send_cmd(0, 4, 12'h010, 12'd1, MODE_VERIFY, 32'h100);
        expect_report(0, 5, 0, "verify_clean");

        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = 12'h012;
        poke_data = 32'hDEAD;
        @(negedge clk);
        poke_en = 1'b0;
        send_cmd(0, 4, 12'h010, 12'd1, MODE_VERIFY, 32'h100);
        expect_report(0, 5, 1, "verify_bad");
        check("read_no_write", wlog_a.size(), 4);

        send_cmd(0, 3, 12'hFFE, 12'd3, MODE_WRITE, 32'h0);
        expect_report(0, 4, 3, "wrap");
        check("wrap_addr0", wlog_a[4], 12'hFFE);
        check("wrap_addr1", wlog_a[5], 12'h001);
        check("wrap_addr2", wlog_a[6], 12'h004);

        send_cmd(0, 0, 12'h300, 12'd1, MODE_WRITE, 32'h7);
        expect_report(0, 0, 0, "len0");
        check("len0_no_write", wlog_a.size(), 7);
        send_cmd(0, 2, 12'h300, 12'd1, MODE_IDLE, 32'h7);
        expect_report(0, 3, 0, "idle_mode");
        check("idle_no_write", wlog_a.size(), 7);

        // gaps between command words, then stall in REP0 under backpressure
        a_full = 1'b1;
        push_word(0, 32'h0000_0001);
        repeat (4) @(negedge clk);
        push_word(0, w1(12'h020, 12'd1, MODE_WRITE));
        repeat (3) @(negedge clk);
        push_word(0, 32'h5);
        k = 0;
        while (dut_a.state !== ST_REP0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        assert (k < 100) else begin
            miscompares++;
            $error("FAIL bp_reach_rep0: observed %0d cycles expected under 100", k);
        end
        enq_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_enq) enq_seen++;
        end
        check("bp_enq", enq_seen, 0);
        check("bp_state", dut_a.state, ST_REP0);
        check("bp_no_report", rep_a.size(), ra);
        a_full = 1'b0;
        expect_report(0, 2, 5, "backpressure");
        check("bp_write_addr", wlog_a[7], 12'h020);

        send_cmd(1, 2, 12'h000, 12'd1, MODE_WRITE, 32'h0);
        expect_report(1, 3, 28, "simd4_write");
        check("simd4_word0", mem_b[0], {32'd3, 32'd2, 32'd1, 32'd0});
        check("simd4_word1", mem_b[1], {32'd7, 32'd6, 32'd5, 32'd4});
        send_cmd(1, 2, 12'h000, 12'd1, MODE_READ, 32'h0);
        expect_report(1, 3, 28, "simd4_read");
        send_cmd(1, 2, 12'h000, 12'd1, MODE_VERIFY, 32'h0);
        expect_report(1, 3, 0, "simd4_verify");

        send_cmd(0, 100, 12'h100, 12'd1, MODE_WRITE, 32'h0);
        k = 0;
        while (!a_we && k < 100) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        assert (k < 100) else begin
            miscompares++;
            $error("FAIL midrun_start: observed %0d cycles expected under 100", k);
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_we", a_we, 0);
        check("midrun_rst_addr", a_addr, 0);
        check("midrun_rst_d", a_d, 0);
        check("midrun_rst_enq", a_enq, 0);
        check("midrun_rst_deq", a_deq, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrun_no_report", rep_a.size(), ra);

        send_cmd(0, 2, 12'h040, 12'd1, MODE_WRITE, 32'h10);
        expect_report(0, 3, 32'h21, "after_reset");
        check("no_deq_enq_overlap", both_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
